// File: rtl/execute_if.sv
// execute_if: groups the ID/EX operand/control bus consumed by the EX stage and
// the EX/MEM latch outputs it produces.
// Ports: master = producer of ID/EX fields / consumer of EX/MEM fields; slave = the EX stage.
interface execute_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    // ID/EX side
    logic [1:0]       wb_ctl;       // {regwrite, memtoreg}
    logic [2:0]       m_ctl;        // {branch, memread, memwrite}
    logic             regdst;
    logic             alusrc;
    logic [1:0]       aluop;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [WIDTH-1:0] s_extend;
    logic [RD_W-1:0]  instr_2016;
    logic [RD_W-1:0]  instr_1511;

    // EX/MEM side
    logic [1:0]       ex_mem_wb;
    logic [2:0]       ex_mem_m;
    logic [WIDTH-1:0] ex_mem_add_result;
    logic             ex_mem_zero;
    logic [WIDTH-1:0] ex_mem_alu_result;
    logic [WIDTH-1:0] ex_mem_rdata2;
    logic [RD_W-1:0]  ex_mem_rd;
    logic             ex_overflow;

    modport master (
        output wb_ctl, m_ctl, regdst, alusrc, aluop, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        input  ex_mem_wb, ex_mem_m, ex_mem_add_result, ex_mem_zero,
               ex_mem_alu_result, ex_mem_rdata2, ex_mem_rd, ex_overflow
    );

    modport slave (
        input  wb_ctl, m_ctl, regdst, alusrc, aluop, npc, rdata1, rdata2,
               s_extend, instr_2016, instr_1511,
        output ex_mem_wb, ex_mem_m, ex_mem_add_result, ex_mem_zero,
               ex_mem_alu_result, ex_mem_rdata2, ex_mem_rd, ex_overflow
    );
endinterface

// File: rtl/execute.sv
// MIPS EX stage: ALU control decode, ALU, operand/destination muxing, branch target, EX/MEM latch.
// Latency 1 cycle (inputs sampled on the rising edge into the EX/MEM latch).
// Backpressure: stall holds the latch, flush loads a bubble (flush beats stall, rst beats both).
// Ports: clk, rst (sync, active-high), stall, flush, bus (execute_if.slave: ID/EX in, EX/MEM out).
// Optional: define EX_OVERFLOW_EN to flag signed add/sub overflow and squash regwrite/memwrite.
module execute #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      flush,
    execute_if.slave  bus
);
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_BAD = 3'b011,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_t;

    alu_ctl_t         alu_ctl;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] add_result;
    logic [RD_W-1:0]  dest;
    logic [1:0]       wb_nxt;
    logic [2:0]       m_nxt;

    // ALU control: funct lives in the low bits of the sign-extended immediate.
    always_comb begin
        alu_ctl = ALU_BAD;
        unique case (bus.aluop)
            2'b00: alu_ctl = ALU_ADD;
            2'b01: alu_ctl = ALU_SUB;
            2'b10: begin
                case (bus.s_extend[5:0])
                    6'b100000: alu_ctl = ALU_ADD;
                    6'b100010: alu_ctl = ALU_SUB;
                    6'b100100: alu_ctl = ALU_AND;
                    6'b100101: alu_ctl = ALU_OR;
                    6'b101010: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_BAD;
                endcase
            end
            default: alu_ctl = ALU_BAD;
        endcase
    end

    assign alu_b = bus.alusrc ? bus.s_extend : bus.rdata2;

    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            ALU_ADD: alu_result = bus.rdata1 + alu_b;
            ALU_SUB: alu_result = bus.rdata1 - alu_b;
            ALU_AND: alu_result = bus.rdata1 & alu_b;
            ALU_OR:  alu_result = bus.rdata1 | alu_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(bus.rdata1) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    // Branch target is always computed; MEM decides whether to use it.
    assign add_result = bus.npc + (bus.s_extend << 2);
    assign dest       = bus.regdst ? bus.instr_1511 : bus.instr_2016;

`ifdef EX_OVERFLOW_EN
    logic sign_a;
    logic sign_b;
    logic sign_r;
    logic ovf;

    assign sign_a = bus.rdata1[WIDTH-1];
    assign sign_b = alu_b[WIDTH-1];
    assign sign_r = alu_result[WIDTH-1];

    // Subtraction overflows when operand signs differ (B effectively inverted).
    always_comb begin
        ovf = 1'b0;
        if (alu_ctl == ALU_ADD)
            ovf = (sign_a == sign_b) && (sign_r != sign_a);
        else if (alu_ctl == ALU_SUB)
            ovf = (sign_a != sign_b) && (sign_r != sign_a);
    end

    // An overflowing instruction must not commit architectural state.
    assign wb_nxt = {bus.wb_ctl[1] & ~ovf, bus.wb_ctl[0]};
    assign m_nxt  = {bus.m_ctl[2:1], bus.m_ctl[0] & ~ovf};
`else
    assign wb_nxt = bus.wb_ctl;
    assign m_nxt  = bus.m_ctl;
`endif

    // EX/MEM latch
    logic [1:0]       wb_q;
    logic [2:0]       m_q;
    logic [WIDTH-1:0] add_q;
    logic             zero_q;
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] rdata2_q;
    logic [RD_W-1:0]  rd_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wb_q     <= '0;
            m_q      <= '0;
            add_q    <= '0;
            zero_q   <= 1'b0;
            alu_q    <= '0;
            rdata2_q <= '0;
            rd_q     <= '0;
        end else if (!stall) begin
            wb_q     <= wb_nxt;
            m_q      <= m_nxt;
            add_q    <= add_result;
            zero_q   <= (alu_result == '0);
            alu_q    <= alu_result;
            rdata2_q <= bus.rdata2;
            rd_q     <= dest;
        end
    end

`ifdef EX_OVERFLOW_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst || flush)
            ovf_q <= 1'b0;
        else if (!stall)
            ovf_q <= ovf;
    end
    assign bus.ex_overflow = ovf_q;
`else
    assign bus.ex_overflow = 1'b0;
`endif

    assign bus.ex_mem_wb         = wb_q;
    assign bus.ex_mem_m          = m_q;
    assign bus.ex_mem_add_result = add_q;
    assign bus.ex_mem_zero       = zero_q;
    assign bus.ex_mem_alu_result = alu_q;
    assign bus.ex_mem_rdata2     = rdata2_q;
    assign bus.ex_mem_rd         = rd_q;
endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the EX stage: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model of the EX/MEM latch.
module tb_execute;
    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;

    execute_if #(.WIDTH(32), .RD_W(5)) bus();

    execute #(.WIDTH(32), .RD_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        regdst;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [31:0] npc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] sx;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        ovf;
    } exm_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exm_t exp_q;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // What the EX/MEM latch must hold after loading instruction i (plain integer arithmetic).
    function automatic exm_t model_next(input in_t i);
        exm_t        o;
        logic [31:0] b;
        longint      sa, sb, s;
        logic [31:0] res;
        bit          arith;
        bit          ovf;
        b     = i.alusrc ? i.sx : i.r2;
        sa    = longint'($signed(i.r1));
        sb    = longint'($signed(b));
        s     = 0;
        res   = 32'd0;
        arith = 1'b0;
        case (i.aluop)
            2'd0: begin s = sa + sb; arith = 1'b1; end
            2'd1: begin s = sa - sb; arith = 1'b1; end
            2'd2: begin
                case (i.sx[5:0])
                    6'h20: begin s = sa + sb; arith = 1'b1; end
                    6'h22: begin s = sa - sb; arith = 1'b1; end
                    6'h24: res = i.r1 & b;
                    6'h25: res = i.r1 | b;
                    6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
                    default: res = 32'd0;
                endcase
            end
            default: res = 32'd0;
        endcase
        if (arith) res = s[31:0];
        ovf    = arith && (s > 64'sd2147483647 || s < -64'sd2147483648);
        o.wb   = i.wb;
        o.m    = i.m;
        o.add  = i.npc + i.sx * 32'd4;
        o.zero = (res == 32'd0);
        o.alu  = res;
        o.r2   = i.r2;
        o.rd   = i.regdst ? i.rd : i.rt;
`ifdef EX_OVERFLOW_EN
        o.ovf = ovf;
        if (ovf) begin
            o.wb[1] = 1'b0;
            o.m[0]  = 1'b0;
        end
`else
        o.ovf = 1'b0;
`endif
        return o;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic tick(input in_t i, input logic st, input logic fl, input logic rs);
        exm_t nxt;
        bus.wb_ctl     = i.wb;
        bus.m_ctl      = i.m;
        bus.regdst     = i.regdst;
        bus.alusrc     = i.alusrc;
        bus.aluop      = i.aluop;
        bus.npc        = i.npc;
        bus.rdata1     = i.r1;
        bus.rdata2     = i.r2;
        bus.s_extend   = i.sx;
        bus.instr_2016 = i.rt;
        bus.instr_1511 = i.rd;
        stall = st;
        flush = fl;
        rst   = rs;
        if (rs || fl)  nxt = '0;
        else if (st)   nxt = exp_q;
        else           nxt = model_next(i);
        @(posedge clk);
        #1;
        exp_q = nxt;
    endtask

    // Per-cycle comparison of every latch output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb",   {30'd0, bus.ex_mem_wb},        {30'd0, exp_q.wb});
            chk("m",    {29'd0, bus.ex_mem_m},         {29'd0, exp_q.m});
            chk("add",  bus.ex_mem_add_result,         exp_q.add);
            chk("zero", {31'd0, bus.ex_mem_zero},      {31'd0, exp_q.zero});
            chk("alu",  bus.ex_mem_alu_result,         exp_q.alu);
            chk("r2",   bus.ex_mem_rdata2,             exp_q.r2);
            chk("rd",   {27'd0, bus.ex_mem_rd},        {27'd0, exp_q.rd});
            chk("ovf",  {31'd0, bus.ex_overflow},      {31'd0, exp_q.ovf});
        end
    end

    task automatic chk_zero_latch(input string tag);
        chk({tag, "_wb"},  {30'd0, bus.ex_mem_wb},   32'd0);
        chk({tag, "_m"},   {29'd0, bus.ex_mem_m},    32'd0);
        chk({tag, "_add"}, bus.ex_mem_add_result,    32'd0);
        chk({tag, "_alu"}, bus.ex_mem_alu_result,    32'd0);
        chk({tag, "_r2"},  bus.ex_mem_rdata2,        32'd0);
        chk({tag, "_rd"},  {27'd0, bus.ex_mem_rd},   32'd0);
        chk({tag, "_z"},   {31'd0, bus.ex_mem_zero}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] edges [4];
        edges[0] = 32'h7FFF_FFFF;
        edges[1] = 32'h8000_0000;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h0000_0000;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return $urandom();
    endfunction

    function automatic in_t rnd_in();
        in_t         v;
        logic [5:0]  functs [6];
        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
        functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'($urandom());
        v.wb     = 2'($urandom());
        v.m      = 3'($urandom());
        v.regdst = 1'($urandom());
        v.alusrc = 1'($urandom());
        v.aluop  = 2'($urandom());
        v.npc    = $urandom() & 32'hFFFF_FFFC;
        v.r1     = rnd_word();
        v.r2     = ($urandom_range(0, 4) == 0) ? v.r1 : rnd_word();
        v.sx     = ($urandom_range(0, 1) == 0) ? rnd_word() : 32'($signed(16'($urandom())));
        if (v.aluop == 2'b10) v.sx[5:0] = functs[$urandom_range(0, 5)];
        v.rt     = 5'($urandom());
        v.rd     = 5'($urandom());
        return v;
    endfunction

    initial begin
        in_t v;
        in_t add_instr;
        exp_q = '0;
        v     = '0;

        // Reset state
        tick(v, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk_zero_latch("reset");

        // R-type add 5+3 -> rd 7
        add_instr = '0;
        add_instr.aluop = 2'b10; add_instr.sx = 32'h20; add_instr.r1 = 32'd5;
        add_instr.r2 = 32'd3; add_instr.regdst = 1'b1; add_instr.rd = 5'd7;
        add_instr.wb = 2'b10;
        tick(add_instr, 1'b0, 1'b0, 1'b0);
        chk("radd_alu",  bus.ex_mem_alu_result,       32'd8);
        chk("radd_zero", {31'd0, bus.ex_mem_zero},    32'd0);
        chk("radd_rd",   {27'd0, bus.ex_mem_rd},      32'd7);
        chk("radd_wb",   {30'd0, bus.ex_mem_wb},      32'd2);

        // beq taken
        v = '0;
        v.aluop = 2'b01; v.r1 = 32'd9; v.r2 = 32'd9; v.npc = 32'h100; v.sx = 32'd4;
        v.m = 3'b100;
        tick(v, 1'b0, 1'b0, 1'b0);
        chk("beq_zero", {31'd0, bus.ex_mem_zero}, 32'd1);
        chk("beq_add",  bus.ex_mem_add_result,    32'h110);
        chk("beq_m",    {29'd0, bus.ex_mem_m},    32'd4);

        // lw address with negative offset
        v = '0;
        v.aluop = 2'b00; v.alusrc = 1'b1; v.r1 = 32'h1000; v.sx = 32'hFFFF_FFFC;
        v.rt = 5'd9; v.wb = 2'b11; v.m = 3'b010;
        tick(v, 1'b0, 1'b0, 1'b0);
        chk("lw_alu", bus.ex_mem_alu_result,  32'h0000_0FFC);
        chk("lw_rd",  {27'd0, bus.ex_mem_rd}, 32'd9);

        // signed slt: -1 < 1
        v = '0;
        v.aluop = 2'b10; v.sx = 32'h2A; v.r1 = 32'hFFFF_FFFF; v.r2 = 32'd1;
        tick(v, 1'b0, 1'b0, 1'b0);
        chk("slt_alu", bus.ex_mem_alu_result, 32'd1);

        // aluop 11 gives 0
        v.aluop = 2'b11; v.r1 = 32'd123; v.r2 = 32'd5;
        tick(v, 1'b0, 1'b0, 1'b0);
        chk("op11_alu", bus.ex_mem_alu_result, 32'd0);
        chk("op11_z",   {31'd0, bus.ex_mem_zero}, 32'd1);

        // Stall holds for 3 cycles with changing inputs
        tick(add_instr, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(rnd_in(), 1'b1, 1'b0, 1'b0);
            chk("stall_alu", bus.ex_mem_alu_result, 32'd8);
            chk("stall_rd",  {27'd0, bus.ex_mem_rd}, 32'd7);
        end
        // stall + flush -> bubble
        tick(rnd_in(), 1'b1, 1'b1, 1'b0);
        chk_zero_latch("flush");

        // Reset during stall with nonzero latch, then release
        tick(add_instr, 1'b0, 1'b0, 1'b0);
        tick(rnd_in(), 1'b1, 1'b0, 1'b1);
        chk_zero_latch("rststall");
        tick(add_instr, 1'b0, 1'b0, 1'b0);
        chk("rel_alu", bus.ex_mem_alu_result, 32'd8);

        // Signed overflow on addi
        v = '0;
        v.aluop = 2'b00; v.r1 = 32'h7FFF_FFFF; v.alusrc = 1'b1; v.sx = 32'd1;
        v.wb = 2'b10; v.m = 3'b001;
        tick(v, 1'b0, 1'b0, 1'b0);
        chk("ovf_alu", bus.ex_mem_alu_result, 32'h8000_0000);
`ifdef EX_OVERFLOW_EN
        chk("ovf_flag", {31'd0, bus.ex_overflow}, 32'd1);
        chk("ovf_wb",   {30'd0, bus.ex_mem_wb},   32'd0);
        chk("ovf_m",    {29'd0, bus.ex_mem_m},    32'd0);
`else
        chk("ovf_flag", {31'd0, bus.ex_overflow}, 32'd0);
        chk("ovf_wb",   {30'd0, bus.ex_mem_wb},   32'd2);
        chk("ovf_m",    {29'd0, bus.ex_mem_m},    32'd1);
`endif

        // Randomized traffic with occasional stall/flush/reset
        for (int n = 0; n < 400; n++) begin
            tick(rnd_in(),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 3));
        end

        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/execute.md
Name: execute

Overview:
- EX stage of the 5-stage MIPS pipeline. Consumes the ID/EX latch outputs: control bundles, NPC, both register operands, the sign-extended immediate and the two destination fields.
- Performs ALU control decode, ALU operation, operand/destination muxing and branch-target calculation.
- Registers all results into an internal EX/MEM latch that feeds the MEM stage.
- Supports pipeline stall (hold) and flush (bubble insert).

Parameters:
- WIDTH, 32, datapath width of operands, results and NPC.
- RD_W, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the EX/MEM latch contents.
- flush  in  1  load a bubble into the EX/MEM latch.
- wb_ctl  in  2  {regwrite, memtoreg} from ID/EX.
- m_ctl  in  3  {branch, memread, memwrite} from ID/EX.
- regdst  in  1  1 selects instr_1511 as destination; 0 selects instr_2016.
- alusrc  in  1  1 selects s_extend as ALU operand B; 0 selects rdata2.
- aluop  in  2  ALU operation class.
- npc  in  WIDTH  PC+4 of the instruction.
- rdata1  in  WIDTH  operand A.
- rdata2  in  WIDTH  operand B / store data.
- s_extend  in  WIDTH  sign-extended immediate; bits [5:0] are funct.
- instr_2016  in  RD_W  rt field.
- instr_1511  in  RD_W  rd field.
- ex_mem_wb  out  2  latched wb_ctl.
- ex_mem_m  out  3  latched m_ctl.
- ex_mem_add_result  out  WIDTH  latched branch target.
- ex_mem_zero  out  1  latched ALU zero flag.
- ex_mem_alu_result  out  WIDTH  latched ALU result.
- ex_mem_rdata2  out  WIDTH  latched rdata2 (store data).
- ex_mem_rd  out  RD_W  latched destination register.
- ex_overflow  out  1  latched signed-overflow flag (see Optional Feature).

Behaviour:
- ALU control (combinational):
  - aluop 00 → add.
  - aluop 01 → sub.
  - aluop 10 → decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - aluop 11, or any other funct → result 0.
- Internal ALU codes: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 invalid.
- ALU arithmetic:
  - B = alusrc ? s_extend : rdata2.
  - add/sub wrap modulo 2^WIDTH.
  - slt is signed; result is 1 or 0, zero-extended.
  - zero = (result == 0).
- Branch target: npc + (s_extend << 2), modulo 2^WIDTH, computed regardless of the branch bit.
- Destination: regdst ? instr_1511 : instr_2016.
- EX/MEM latch: latency 1 cycle. Priority at each rising edge is rst > flush > stall > load.
  - rst: every output = 0.
  - flush: every output = 0 (bubble: no regwrite, no memory access, no branch).
  - stall (flush=0): all outputs hold their previous values.
  - otherwise: all outputs load the current EX results.
- Reset mid-stall or with flush asserted: reset wins; outputs are 0 on the next edge.
- Simultaneous stall and flush: flush wins.
- Inputs are not registered inside the block; they are sampled only at the latch edge.

Optional Feature:
- Macro: EX_OVERFLOW_EN.
- Defined:
  - ex_overflow latches 1 when an add/sub produces signed overflow: operand signs equal for add (B inverted for sub) and result sign differs.
  - On overflow, ex_mem_wb[1] (regwrite) and ex_mem_m[0] (memwrite) are forced to 0 in the latch.
  - All other fields latch normally.
- Undefined:
  - ex_overflow is constant 0.
  - Overflow wraps silently; control bits pass unchanged.

Test Plan:
- R-type add: aluop=10, funct=100000, rdata1=5, rdata2=3, regdst=1, instr_1511=7, wb_ctl=10 → next edge: alu_result=8, zero=0, rd=7, wb=10.
- beq taken: aluop=01, rdata1=rdata2=9, npc=0x100, s_extend=4, m_ctl=100 → zero=1, add_result=0x110, m=100.
- lw: aluop=00, alusrc=1, rdata1=0x1000, s_extend=0xFFFFFFFC, regdst=0, instr_2016=9 → alu_result=0xFFC, rd=9. slt with rdata1=0xFFFFFFFF, rdata2=1 → alu_result=1.
- Stall/flush: load an add result, then stall=1 for 3 cycles with changing inputs → outputs unchanged. Then stall=1 with flush=1 → all outputs 0.
- Reset: rst=1 during stall with nonzero latch → all outputs 0 next edge. Releasing rst → normal load on the following edge.
- Overflow: aluop=00, rdata1=0x7FFFFFFF, alusrc=1, s_extend=1, wb_ctl=10.
  - With EX_OVERFLOW_EN: ex_overflow=1, ex_mem_wb=00.
  - Without it: alu_result=0x80000000, ex_overflow=0, wb=10.
